rr_req_arbiter: RTL and testbench

//  Round-robin arbiter granting one shared downstream resource to one of N_REQ requesters.

---
 rtl/rr_req_arbiter_pkg.sv | 11 +
 rtl/rr_req_arbiter_if.sv | 31 +++
 rtl/rr_req_arbiter_prio_pick.sv | 31 +++
 rtl/rr_req_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_req_arbiter_pkg.sv
// Shared types and constants for the round-robin request arbiter.
package arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Status code reported when no grant is active (matches the priority encoder).
    localparam logic [7:0] ARB_NO_GRANT = 8'hF0;

    localparam int ARB_IDX_W = 4;

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
//
// Handshake: req_i[k] is a level request held by requester k for as long as it wants
// the resource; the holder keeps the grant while its request stays high and done_i
// is low. All arbiter outputs are registered and change only on the clock edge.
// dbg_state exposes the arbiter FSM state for checkers.
interface rr_req_arbiter_if
    import arb_pkg::*;
#(
    parameter int N_REQ = 16,
    parameter int IDX_W = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req_i;
    logic             done_i;
    logic             gnt_valid_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic [N_REQ-1:0] gnt_onehot_o;
    logic [7:0]       gnt_code_o;
    logic             timeout_o;
    arb_state_t       dbg_state;

    modport slave (
        input  req_i, done_i,
        output gnt_valid_o, gnt_idx_o, gnt_onehot_o, gnt_code_o, timeout_o, dbg_state
    );

    modport master (
        output req_i, done_i,
        input  gnt_valid_o, gnt_idx_o, gnt_onehot_o, gnt_code_o, timeout_o, dbg_state
    );
endinterface

// File: rtl/rr_req_arbiter_prio_pick.sv
// rr_prio_pick: combinational rotating priority search. Returns the first set
// request found when scanning downward from index 'start' with wrap-around.
module rr_prio_pick #(
    parameter int N_REQ = 16,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0]   rot_amt;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   win;

    // Rotating right by start+1 puts 'start' at the MSB, so a plain MSB-first
    // encode then scans start, start-1, ... with wrap-around. N_REQ is a power
    // of two, so IDX_W-bit arithmetic gives the mod N_REQ for free.
    always_comb begin
        rot_amt = start + IDX_W'(1);
        dbl     = {req, req} >> rot_amt;
        rot     = dbl[N_REQ-1:0];
        win     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rot[i]) win = IDX_W'(i);
        end
        found = |req;
        idx   = win + rot_amt;
    end
endmodule

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter for one shared resource among N_REQ requesters.
// The search starts just below the last granted index, so the previous holder has
// lowest priority next time. Optional macro ARB_TIMEOUT_EN adds a hold counter that
// force-releases a grant after MAX_HOLD cycles and pulses timeout_o.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 16,
    parameter int IDX_W    = ARB_IDX_W,
    parameter int MAX_HOLD = 8
) (
    input logic         clk,
    input logic         rst,
    rr_req_arbiter_if.slave arb
);
    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("MAX_HOLD must be in 1..255");
        end
    endgenerate

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] search_start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             natural_rel;
    logic             force_rel;
    logic             grant_now;
    logic             valid_d;
    logic [IDX_W-1:0] idx_d;
    logic [N_REQ-1:0] onehot_d;
    logic [7:0]       code_d;
    logic             timeout_d;

    assign search_start = ptr_q - IDX_W'(1);

    rr_prio_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (arb.req_i),
        .start (search_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // ptr always equals the current holder while in GRANT.
    assign natural_rel = arb.done_i | ~arb.req_i[ptr_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt_q;

    assign force_rel = (state_q == ARB_GRANT) && !natural_rel && (hold_cnt_q == HOLD_LAST);

    // Hold counter: cleared on every grant, counts cycles the grant is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     hold_cnt_q <= '0;
        else if (grant_now || state_d == ARB_IDLE)   hold_cnt_q <= '0;
        else                                         hold_cnt_q <= hold_cnt_q + 8'd1;
    end
`else
    assign force_rel = 1'b0;
`endif

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        valid_d   = 1'b0;
        idx_d     = '0;
        timeout_d = 1'b0;
        grant_now = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) grant_now = 1'b1;
            end
            ARB_GRANT: begin
                if (natural_rel || force_rel) begin
                    timeout_d = force_rel;
                    if (pick_found) grant_now = 1'b1;
                    else            state_d   = ARB_IDLE;
                end else begin
                    valid_d = 1'b1;
                    idx_d   = ptr_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (grant_now) begin
            state_d = ARB_GRANT;
            ptr_d   = pick_idx;
            valid_d = 1'b1;
            idx_d   = pick_idx;
        end
        onehot_d = valid_d ? (N_REQ'(1) << idx_d) : '0;
        code_d   = valid_d ? {{(8 - IDX_W){1'b0}}, idx_d} : ARB_NO_GRANT;
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ARB_IDLE;
            ptr_q            <= '0;
            arb.gnt_valid_o  <= 1'b0;
            arb.gnt_idx_o    <= '0;
            arb.gnt_onehot_o <= '0;
            arb.gnt_code_o   <= ARB_NO_GRANT;
            arb.timeout_o    <= 1'b0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            arb.gnt_valid_o  <= valid_d;
            arb.gnt_idx_o    <= idx_d;
            arb.gnt_onehot_o <= onehot_d;
            arb.gnt_code_o   <= code_d;
            arb.timeout_o    <= timeout_d;
        end
    end

    assign arb.dbg_state = state_q;
endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_rr_req_arbiter;
    import arb_pkg::*;

    localparam int N        = 16;
    localparam int MAX_HOLD = 4;
    localparam int OUT_W    = 26; // {valid, onehot[15:0], code[7:0], timeout}

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic        exp_valid;
        int          exp_idx;
        logic        exp_to;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [OUT_W-1:0] exp_q[$];

    rr_req_arbiter_if #(.N_REQ(N)) bus ();

    rr_req_arbiter #(.N_REQ(N), .IDX_W(4), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Holder is -1 when nothing is granted.
    int m_holder;
    int m_ptr;
    int m_hold;
    logic m_to;

    function automatic int m_search(input logic [15:0] r, input int ptr);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (ptr - k + N) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_ptr    = 0;
        m_hold   = 0;
        m_to     = 1'b0;
    endtask

    task automatic model_edge(input logic [15:0] r, input logic d);
        bit rel;
        bit frc;
        int w;
        m_to = 1'b0;
        if (m_holder < 0) begin
            w = m_search(r, m_ptr);
            if (w >= 0) begin
                m_holder = w; m_ptr = w; m_hold = 0;
            end
        end else begin
            rel = d || !r[m_holder];
            frc = 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (!rel && m_hold == MAX_HOLD - 1) frc = 1'b1;
`endif
            m_to = frc;
            if (rel || frc) begin
                w = m_search(r, m_ptr);
                m_hold = 0;
                if (w >= 0) begin
                    m_holder = w; m_ptr = w;
                end else begin
                    m_holder = -1;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    function automatic logic [OUT_W-1:0] mk(input logic v, input int idx, input logic to);
        logic [15:0] oh;
        logic [7:0]  code;
        oh   = v ? (16'd1 << idx) : 16'd0;
        code = v ? 8'(idx) : 8'hF0;
        return {v, oh, code, to};
    endfunction

    function automatic logic [OUT_W-1:0] model_out();
        return mk(m_holder >= 0, (m_holder >= 0) ? m_holder : 0, m_to);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic [15:0] r, input logic d);
        bus.req_i  = r;
        bus.done_i = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        bus.req_i  = '0;
        bus.done_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [OUT_W-1:0 ] exp);
        logic [OUT_W-1:0] act;
        act = {bus.gnt_valid_o, bus.gnt_onehot_o, bus.gnt_code_o, bus.timeout_o};
        total++;
        if (act !== exp || (exp[OUT_W-1] && bus.gnt_idx_o !== exp[8:1] - 8'd0 && bus.gnt_idx_o !== 4'(exp[4:1]))) begin
            bad++;
            $display("FAIL %s: got valid=%b idx=%0d onehot=%h code=%h to=%b, want valid=%b onehot=%h code=%h to=%b",
                     name, act[25], bus.gnt_idx_o, act[24:9], act[8:1], act[0],
                     exp[25], exp[24:9], exp[8:1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[16];
        int   seen[N];
        int   pulses;
        logic [OUT_W-1:0] e;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_i  = 16'h8001;
        bus.done_i = 1'b0;
        model_reset();

        // Reset state, including while requests are already pending.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", mk(1'b0, 0, 1'b0));
        check_int("reset_state", int'(bus.dbg_state), int'(ARB_IDLE));
        rst = 1'b0;

        // Vector table: MSB-first start, alternation, abandon, idle, re-grant.
        vecs = '{
            '{16'h8001, 1'b0, 1'b1, 15, 1'b0},
            '{16'h8001, 1'b0, 1'b1, 15, 1'b0},
            '{16'h8001, 1'b1, 1'b1,  0, 1'b0},
            '{16'h8001, 1'b0, 1'b1,  0, 1'b0},
            '{16'h8001, 1'b0, 1'b1,  0, 1'b0},
            '{16'h8001, 1'b1, 1'b1, 15, 1'b0},
            '{16'h8001, 1'b0, 1'b1, 15, 1'b0},
            '{16'h0020, 1'b1, 1'b1,  5, 1'b0},
            '{16'h0020, 1'b0, 1'b1,  5, 1'b0},
            '{16'h0008, 1'b0, 1'b1,  3, 1'b0},
            '{16'h0000, 1'b1, 1'b0,  0, 1'b0},
            '{16'h0000, 1'b0, 1'b0,  0, 1'b0},
            '{16'h0000, 1'b1, 1'b0,  0, 1'b0},
            '{16'h0004, 1'b0, 1'b1,  2, 1'b0},
            '{16'h0004, 1'b1, 1'b1,  2, 1'b0},
            '{16'h0000, 1'b0, 1'b0,  0, 1'b0}
        };
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d", i), mk(vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_to));
        end

        // All requesting, done every cycle: 15 down to 0 then 15, each once per 16 grants.
        do_reset();
        step(16'hFFFF, 1'b0);
        check("all_first", mk(1'b1, 15, 1'b0));
        for (int i = 0; i < N; i++) seen[i] = 0;
        for (int k = 1; k <= N; k++) begin
            step(16'hFFFF, 1'b1);
            check($sformatf("all_rr%0d", k), mk(1'b1, (15 - k + N) % N, 1'b0));
            seen[bus.gnt_idx_o]++;
        end
        begin
            int ok;
            ok = 0;
            for (int i = 0; i < N; i++) if (seen[i] == 1) ok++;
            check_int("all_fair_count", ok, N);
        end

        // Hold with requests 0 and 1 and no done: timeout rotation or a held grant.
        do_reset();
        step(16'h0003, 1'b0);
        check("hold_first", mk(1'b1, 1, 1'b0));
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            step(16'h0003, 1'b0);
            check($sformatf("hold%0d", k), model_out());
            if (bus.timeout_o) pulses++;
        end
`ifdef ARB_TIMEOUT_EN
        check_int("timeout_pulses", pulses, 3);
`else
        check_int("timeout_pulses", pulses, 0);
        check("hold_persist", mk(1'b1, 1, 1'b0));
`endif

        // Asynchronous reset mid-grant, then search restarts at index 15.
        do_reset();
        step(16'h0001, 1'b0);
        step(16'h0001, 1'b0);
        check("pre_async", mk(1'b1, 0, 1'b0));
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset", mk(1'b0, 0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(16'h8001, 1'b0);
        check("after_async", mk(1'b1, 15, 1'b0));

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            logic [15:0] r;
            logic        d;
            r = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom & $urandom);
            d = ($urandom_range(0, 3) == 0);
            step(r, d);
            exp_q.push_back(model_out());
            e = exp_q.pop_front();
            check($sformatf("rand%0d", k), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog");
    end
endmodule
